// File: rtl/sram_like_responder.sv
// rtl/sram_like_responder.sv - SRAM-like req/addr_ok/data_ok responder with in-order latency queue and word memory
module sram_like_responder #(
  parameter int MEM_AW      = 10,
  parameter int ADDR_LAT    = 0,
  parameter int DATA_LAT    = 1,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  input  logic              init_we,
  input  logic [MEM_AW-1:0] init_addr,
  input  logic [31:0]       init_data
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  // Age is "edges already seen since the handshake edge"; an entry retires on
  // the edge where that count equals DATA_LAT-1, so DATA_LAT=1 retires on the
  // handshake edge itself.
  localparam logic [3:0]    AGE_MAX   = 4'(DATA_LAT - 1);
  localparam logic [3:0]    ENQ_AGE   = (DATA_LAT > 1) ? 4'd1 : 4'd0;
  // The stall counter saturates at ADDR_LAT: once the latency is met it stays met.
  localparam logic [3:0]    STALL_MAX = 4'(ADDR_LAT);
  localparam logic [CW-1:0] FULL_CNT  = CW'(QUEUE_DEPTH);

  // Backing memory, never reset
  logic [31:0] r_mem [2**MEM_AW];

  // Transaction queue storage
  logic              r_q_wr    [QUEUE_DEPTH];
  logic [3:0]        r_q_wstrb [QUEUE_DEPTH];
  logic [MEM_AW-1:0] r_q_idx   [QUEUE_DEPTH];
  logic [31:0]       r_q_wdata [QUEUE_DEPTH];
  logic [3:0]        r_age     [QUEUE_DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_stall_cnt;
  logic          r_data_ok;
  logic [31:0]   r_rdata;

  logic              w_full;
  logic              w_q_empty;
  logic              w_lat_ok;
  logic              w_addr_ok;
  logic              w_hs;
  logic              w_head_ret;
  logic              w_bypass;
  logic              w_retire;
  logic              w_enq;
  logic [MEM_AW-1:0] w_addr_idx;
  logic              w_ret_wr;
  logic [3:0]        w_ret_strb;
  logic [MEM_AW-1:0] w_ret_idx;
  logic [31:0]       w_ret_wdata;
  logic [31:0]       w_merged;
  logic              w_unused_bits;

  // Size is informational and the byte offset / high address bits do not select storage
  assign w_unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

  assign w_addr_idx = addr[MEM_AW+1:2];
  assign w_q_empty  = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_lat_ok   = (r_stall_cnt == STALL_MAX);
  assign w_addr_ok  = req & ~rst & ~w_full & w_lat_ok;
  assign w_hs       = w_addr_ok;

  // Oldest queued entry retires when it has aged enough; with an empty queue and
  // DATA_LAT=1 the incoming request retires straight through on its handshake edge.
  assign w_head_ret = ~rst & ~w_q_empty & (r_age[r_rptr] == AGE_MAX);
  assign w_bypass   = w_hs & w_q_empty & (AGE_MAX == 4'd0);
  assign w_retire   = w_head_ret | w_bypass;
  assign w_enq      = w_hs & ~w_bypass;

  assign addr_ok = w_addr_ok;
  assign data_ok = r_data_ok;
  assign rdata   = r_rdata;

  // Select the retiring transaction: queue head, or the bypassing request
  always_comb begin
    w_ret_wr    = r_q_wr[r_rptr];
    w_ret_strb  = r_q_wstrb[r_rptr];
    w_ret_idx   = r_q_idx[r_rptr];
    w_ret_wdata = r_q_wdata[r_rptr];
    if (w_bypass) begin
      w_ret_wr    = wr;
      w_ret_strb  = wstrb;
      w_ret_idx   = w_addr_idx;
      w_ret_wdata = wdata;
    end
  end

  // Byte-lane merge of the retiring write into the current memory word
  always_comb begin
    w_merged = r_mem[w_ret_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_ret_strb[b]) begin
        w_merged[8*b +: 8] = w_ret_wdata[8*b +: 8];
      end
    end
  end

  // Memory writes: preload first so a retiring queued write to the same word wins
  always_ff @(posedge clk) begin
    if (init_we) begin
      r_mem[init_addr] <= init_data;
    end
    if (w_retire && w_ret_wr) begin
      r_mem[w_ret_idx] <= w_merged;
    end
  end

  // Queue payload capture and per-entry aging (occupancy is tracked by r_count)
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (w_enq && (PW'(i) == r_wptr)) begin
        r_q_wr[i]    <= wr;
        r_q_wstrb[i] <= wstrb;
        r_q_idx[i]   <= w_addr_idx;
        r_q_wdata[i] <= wdata;
        r_age[i]     <= ENQ_AGE;
      end else if (r_age[i] != AGE_MAX) begin
        r_age[i] <= r_age[i] + 4'd1;
      end
    end
  end

  // Queue pointers and occupancy; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= (QUEUE_DEPTH == 1) ? '0 : r_wptr + 1'b1;
      end
      if (w_head_ret) begin
        r_rptr <= (QUEUE_DEPTH == 1) ? '0 : r_rptr + 1'b1;
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_head_ret);
    end
  end

  // Address-phase wait counter: counts held-request cycles, restarts on accept or idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 4'd0;
    end else if (w_hs || !req) begin
      r_stall_cnt <= 4'd0;
    end else if (r_stall_cnt != STALL_MAX) begin
      r_stall_cnt <= r_stall_cnt + 4'd1;
    end
  end

  // Completion pulse and response data; rdata holds between completions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_ok <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_data_ok <= w_retire;
      if (w_retire) begin
        r_rdata <= w_ret_wr ? 32'd0 : r_mem[w_ret_idx];
      end
    end
  end

endmodule
